// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter that lets NUM_MASTERS native-interface masters share
// one memory port. Addresses are converted from bytes to words. Reads are
// tracked through a fixed-latency pipeline so that each master sees
// m_rvalid only for its own read data.
module mem_rr_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_ADDR_W  = 30,
   parameter int MEM_LATENCY = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_MASTERS-1:0]          m_req,
   input  logic [NUM_MASTERS-1:0]          m_we,
   input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
   input  logic [NUM_MASTERS*DATA_W/8-1:0] m_be,
   output logic [NUM_MASTERS-1:0]          m_gnt,
   output logic [NUM_MASTERS-1:0]          m_rvalid,
   output logic [DATA_W-1:0]               m_rdata,
   output logic                            mem_re,
   output logic                            mem_we,
   output logic [MEM_ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]               mem_wdata,
   output logic [DATA_W/8-1:0]             mem_be,
   input  logic [DATA_W-1:0]               mem_rdata
);

   localparam int BE_W = DATA_W / 8;
   localparam int OFFS = (BE_W > 1) ? $clog2(BE_W) : 0;
   localparam int ID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   // Round-robin pointer: index of the master with highest priority this cycle.
   logic [ID_W-1:0] rr_ptr_q;
   logic [ID_W-1:0] rr_ptr_d;

   // Arbitration result.
   logic            gnt_found;
   logic [ID_W-1:0] gnt_idx;
   logic [ID_W:0]   cand;
   logic [ID_W:0]   ptr_nxt;
   logic [NUM_MASTERS-1:0] gnt_vec;

   // Fields of the granted master.
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [ADDR_W-1:0] addr_shift;
   logic [DATA_W-1:0] sel_wdata;
   logic [BE_W-1:0]   sel_be;

   // Read-tracking pipeline: one {valid, id} entry per cycle of memory latency.
   logic [MEM_LATENCY-1:0] pipe_vld_q;
   logic [ID_W-1:0]        pipe_id_q [MEM_LATENCY];

   // Search requests from rr_ptr upward, wrapping; reset suppresses any grant.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      if (!rst) begin
         for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_MASTERS)) begin
               cand = cand - (ID_W+1)'(NUM_MASTERS);
            end
            if (!gnt_found && m_req[cand[ID_W-1:0]]) begin
               gnt_found = 1'b1;
               gnt_idx   = cand[ID_W-1:0];
            end
         end
      end
   end

   // One-hot grant vector from the winning index.
   always_comb begin
      gnt_vec = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         gnt_vec[i] = gnt_found && (gnt_idx == ID_W'(i));
      end
   end

   // AND-OR mux of the granted master's request fields; all zero when idle.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (gnt_vec[i]) begin
            sel_we    = sel_we | m_we[i];
            sel_addr  = sel_addr  | m_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = sel_wdata | m_wdata[i*DATA_W +: DATA_W];
            sel_be    = sel_be    | m_be[i*BE_W +: BE_W];
         end
      end
   end

   assign addr_shift = sel_addr >> OFFS;

   // Byte address to word address, truncated or zero-extended to the memory width.
   generate
      if (MEM_ADDR_W <= ADDR_W) begin : g_addr_trunc
         assign mem_addr = addr_shift[MEM_ADDR_W-1:0];
      end else begin : g_addr_ext
         assign mem_addr = {{(MEM_ADDR_W-ADDR_W){1'b0}}, addr_shift};
      end
   endgenerate

   assign m_gnt     = gnt_vec;
   assign mem_re    = gnt_found & ~sel_we;
   assign mem_we    = gnt_found &  sel_we;
   assign mem_wdata = sel_wdata;
   assign mem_be    = sel_be;
   assign m_rdata   = mem_rdata;

   // Next pointer: the master just served drops to lowest priority.
   always_comb begin
      ptr_nxt = {1'b0, gnt_idx} + (ID_W+1)'(1);
      if (ptr_nxt >= (ID_W+1)'(NUM_MASTERS)) begin
         ptr_nxt = '0;
      end
      rr_ptr_d = gnt_found ? ptr_nxt[ID_W-1:0] : rr_ptr_q;
   end

   generate
      if (NUM_MASTERS > 1) begin : g_ptr
         // Pointer register, restarts at master 0 on reset.
         always_ff @(posedge clk) begin
            if (rst) begin
               rr_ptr_q <= '0;
            end else begin
               rr_ptr_q <= rr_ptr_d;
            end
         end
      end else begin : g_ptr_const
         assign rr_ptr_q = '0;
      end
   endgenerate

   // Read tracker: stage 0 records a granted read, the pipeline shifts every
   // cycle, reset drops everything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld_q <= '0;
         for (int s = 0; s < MEM_LATENCY; s++) begin
            pipe_id_q[s] <= '0;
         end
      end else begin
         pipe_vld_q[0] <= gnt_found & ~sel_we;
         pipe_id_q[0]  <= gnt_idx;
         for (int s = MEM_LATENCY-1; s > 0; s--) begin
            pipe_vld_q[s] <= pipe_vld_q[s-1];
            pipe_id_q[s]  <= pipe_id_q[s-1];
         end
      end
   end

   // Route read-valid to the master whose read reaches the end of the pipeline.
   always_comb begin
      m_rvalid = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         m_rvalid[i] = !rst && pipe_vld_q[MEM_LATENCY-1] &&
                       (pipe_id_q[MEM_LATENCY-1] == ID_W'(i));
      end
   end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: a vector table against a 2-master,
// latency-1 instance backed by a small memory model, and hand-written
// sequences for latency 3, latency 2 with 4 masters, and a single master.
module tb_mem_rr_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pre(input logic [3:0] w);
      case (w)
         4'd2:    pre = 32'hAABB_CCDD;
         4'd4:    pre = 32'hDEAD_BEEF;
         default: pre = 32'(w) * 32'h1111_1111;
      endcase
   endfunction

   // ---------------- instance A: 2 masters, latency 1 ----------------
   logic        a_rst;
   logic [1:0]  a_req, a_we, a_gnt, a_rvalid;
   logic [63:0] a_addr, a_wdata;
   logic [7:0]  a_be;
   logic [31:0] a_rdata, a_mwdata, a_mrdata;
   logic        a_mre, a_mwe;
   logic [29:0] a_maddr;
   logic [3:0]  a_mbe;
   logic [31:0] mem_a [16];

   mem_rr_arbiter #(.NUM_MASTERS(2), .MEM_LATENCY(1)) dut_a (
      .clk(clk), .rst(a_rst), .m_req(a_req), .m_we(a_we), .m_addr(a_addr),
      .m_wdata(a_wdata), .m_be(a_be), .m_gnt(a_gnt), .m_rvalid(a_rvalid),
      .m_rdata(a_rdata), .mem_re(a_mre), .mem_we(a_mwe), .mem_addr(a_maddr),
      .mem_wdata(a_mwdata), .mem_be(a_mbe), .mem_rdata(a_mrdata));

   always @(posedge clk) begin
      if (a_mwe) begin
         for (int b = 0; b < 4; b++) begin
            if (a_mbe[b]) mem_a[a_maddr[3:0]][b*8 +: 8] <= a_mwdata[b*8 +: 8];
         end
      end
      a_mrdata <= a_mre ? mem_a[a_maddr[3:0]] : 32'h0;
   end

   // ---------------- instance B: 2 masters, latency 3 ----------------
   logic        b_rst;
   logic [1:0]  b_req, b_we, b_gnt, b_rvalid;
   logic [63:0] b_addr, b_wdata;
   logic [7:0]  b_be;
   logic [31:0] b_rdata, b_mwdata, b_mrdata, b_p0, b_p1;
   logic        b_mre, b_mwe;
   logic [29:0] b_maddr;
   logic [3:0]  b_mbe;

   mem_rr_arbiter #(.NUM_MASTERS(2), .MEM_LATENCY(3)) dut_b (
      .clk(clk), .rst(b_rst), .m_req(b_req), .m_we(b_we), .m_addr(b_addr),
      .m_wdata(b_wdata), .m_be(b_be), .m_gnt(b_gnt), .m_rvalid(b_rvalid),
      .m_rdata(b_rdata), .mem_re(b_mre), .mem_we(b_mwe), .mem_addr(b_maddr),
      .mem_wdata(b_mwdata), .mem_be(b_mbe), .mem_rdata(b_mrdata));

   always @(posedge clk) begin
      b_p0     <= b_mre ? pre(b_maddr[3:0]) : 32'h0;
      b_p1     <= b_p0;
      b_mrdata <= b_p1;
   end

   // ---------------- instance C: 4 masters, latency 2 ----------------
   logic         c_rst;
   logic [3:0]   c_req, c_we, c_gnt, c_rvalid;
   logic [127:0] c_addr, c_wdata;
   logic [15:0]  c_be;
   logic [31:0]  c_rdata, c_mwdata, c_mrdata, c_p0;
   logic         c_mre, c_mwe;
   logic [29:0]  c_maddr;
   logic [3:0]   c_mbe;

   mem_rr_arbiter #(.NUM_MASTERS(4), .MEM_LATENCY(2)) dut_c (
      .clk(clk), .rst(c_rst), .m_req(c_req), .m_we(c_we), .m_addr(c_addr),
      .m_wdata(c_wdata), .m_be(c_be), .m_gnt(c_gnt), .m_rvalid(c_rvalid),
      .m_rdata(c_rdata), .mem_re(c_mre), .mem_we(c_mwe), .mem_addr(c_maddr),
      .mem_wdata(c_mwdata), .mem_be(c_mbe), .mem_rdata(c_mrdata));

   always @(posedge clk) begin
      c_p0     <= c_mre ? pre(c_maddr[3:0]) : 32'h0;
      c_mrdata <= c_p0;
   end

   // ---------------- instance D: 1 master, latency 1 ----------------
   logic        d_rst;
   logic [0:0]  d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata, d_mwdata;
   logic [31:0] d_mrdata = 32'h0BAD_F00D;
   logic [3:0]  d_be, d_mbe;
   logic        d_mre, d_mwe;
   logic [29:0] d_maddr;

   mem_rr_arbiter #(.NUM_MASTERS(1), .MEM_LATENCY(1)) dut_d (
      .clk(clk), .rst(d_rst), .m_req(d_req), .m_we(d_we), .m_addr(d_addr),
      .m_wdata(d_wdata), .m_be(d_be), .m_gnt(d_gnt), .m_rvalid(d_rvalid),
      .m_rdata(d_rdata), .mem_re(d_mre), .mem_we(d_mwe), .mem_addr(d_maddr),
      .mem_wdata(d_mwdata), .mem_be(d_mbe), .mem_rdata(d_mrdata));

   // ---------------- vector table for instance A ----------------
   typedef struct {
      logic        rst;
      logic [1:0]  req;
      logic [1:0]  we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  be;
      logic [1:0]  e_gnt;
      logic        e_re;
      logic        e_we;
      logic [29:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_be;
      logic [1:0]  e_rvalid;
      logic [31:0] e_rdata;
   } vec_t;

   localparam int NV = 18;
   vec_t vt [NV];

   function automatic vec_t mk(
      input logic rst, input logic [1:0] req, input logic [1:0] we,
      input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] be,
      input logic [1:0] e_gnt, input logic e_re, input logic e_we,
      input logic [29:0] e_addr, input logic [31:0] e_wdata, input logic [3:0] e_be,
      input logic [1:0] e_rvalid, input logic [31:0] e_rdata);
      vec_t v;
      v.rst = rst; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
      v.e_gnt = e_gnt; v.e_re = e_re; v.e_we = e_we; v.e_addr = e_addr;
      v.e_wdata = e_wdata; v.e_be = e_be; v.e_rvalid = e_rvalid; v.e_rdata = e_rdata;
      return v;
   endfunction

   // ---------------- hand-written sequence helpers ----------------
   task automatic cyc_b(input logic rst, input logic [1:0] req, input logic [63:0] addr,
                        input logic [1:0] e_gnt, input logic [29:0] e_addr,
                        input logic [1:0] e_rv, input logic [31:0] e_rd, input int n);
      @(posedge clk); #1;
      b_rst = rst; b_req = req; b_addr = addr;
      @(negedge clk);
      chk($sformatf("B%0d gnt", n), 64'(b_gnt), 64'(e_gnt));
      if (e_gnt != 2'b00) chk($sformatf("B%0d mem_addr", n), 64'(b_maddr), 64'(e_addr));
      chk($sformatf("B%0d rvalid", n), 64'(b_rvalid), 64'(e_rv));
      if (e_rv != 2'b00) chk($sformatf("B%0d rdata", n), 64'(b_rdata), 64'(e_rd));
   endtask

   task automatic cyc_c(input logic rst, input logic [3:0] req,
                        input logic [3:0] e_gnt, input logic e_re,
                        input logic [3:0] e_rv, input logic [31:0] e_rd, input int n);
      @(posedge clk); #1;
      c_rst = rst; c_req = req;
      @(negedge clk);
      chk($sformatf("C%0d gnt", n), 64'(c_gnt), 64'(e_gnt));
      chk($sformatf("C%0d mem_re", n), 64'(c_mre), 64'(e_re));
      chk($sformatf("C%0d rvalid", n), 64'(c_rvalid), 64'(e_rv));
      if (e_rv != 4'b0000) chk($sformatf("C%0d rdata", n), 64'(c_rdata), 64'(e_rd));
   endtask

   task automatic cyc_d(input logic rst, input logic req, input logic we,
                        input logic e_gnt, input logic e_we, input logic e_rv, input int n);
      @(posedge clk); #1;
      d_rst = rst; d_req = req; d_we = we;
      @(negedge clk);
      chk($sformatf("D%0d gnt", n), 64'(d_gnt), 64'(e_gnt));
      chk($sformatf("D%0d mem_we", n), 64'(d_mwe), 64'(e_we));
      chk($sformatf("D%0d rvalid", n), 64'(d_rvalid), 64'(e_rv));
      if (e_rv) chk($sformatf("D%0d rdata", n), 64'(d_rdata), 64'h0BAD_F00D);
   endtask

   localparam logic [63:0] AD = 64'h0000_000C_0000_0010;   // m1 -> word 3, m0 -> word 4
   localparam logic [63:0] WD = 64'hB1B1_B1B1_A0A0_A0A0;

   initial begin
      for (int i = 0; i < 16; i++) mem_a[i] = pre(4'(i));
      a_rst = 1'b1; a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_be = '0;
      b_rst = 1'b1; b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_be = '0;
      c_rst = 1'b1; c_req = '0; c_we = '0; c_wdata = '0; c_be = '0;
      c_addr = {32'h14, 32'h08, 32'h0C, 32'h10};   // m3 w5, m2 w2, m1 w3, m0 w4
      d_rst = 1'b1; d_req = '0; d_we = '0; d_addr = 32'h10; d_wdata = 32'h5A5A_5A5A; d_be = 4'hF;

      //        rst  req    we     addr  wdata  be     gnt   re    we   addr  wdata         be    rvalid rdata
      vt[0]  = mk(1, 2'b11, 2'b00, AD, WD, 8'h3F, 2'b00, 0, 0, 30'h0, 32'h0, 4'h0, 2'b00, 32'h0);
      vt[1]  = mk(0, 2'b01, 2'b00, AD, 64'h0, 8'h00, 2'b01, 1, 0, 30'h4, 32'h0, 4'h0, 2'b00, 32'h0);
      vt[2]  = mk(0, 2'b00, 2'b00, AD, 64'h0, 8'h00, 2'b00, 0, 0, 30'h0, 32'h0, 4'h0, 2'b01, 32'hDEAD_BEEF);
      vt[3]  = mk(1, 2'b00, 2'b00, AD, 64'h0, 8'h00, 2'b00, 0, 0, 30'h0, 32'h0, 4'h0, 2'b00, 32'h0);
      vt[4]  = mk(0, 2'b11, 2'b00, AD, WD, 8'h3F, 2'b01, 1, 0, 30'h4, 32'hA0A0_A0A0, 4'hF, 2'b00, 32'h0);
      vt[5]  = mk(0, 2'b11, 2'b00, AD, WD, 8'h3F, 2'b10, 1, 0, 30'h3, 32'hB1B1_B1B1, 4'h3, 2'b01, 32'hDEAD_BEEF);
      vt[6]  = mk(0, 2'b11, 2'b00, AD, WD, 8'h3F, 2'b01, 1, 0, 30'h4, 32'hA0A0_A0A0, 4'hF, 2'b10, 32'h3333_3333);
      vt[7]  = mk(0, 2'b11, 2'b00, AD, WD, 8'h3F, 2'b10, 1, 0, 30'h3, 32'hB1B1_B1B1, 4'h3, 2'b01, 32'hDEAD_BEEF);
      vt[8]  = mk(0, 2'b00, 2'b00, AD, WD, 8'h3F, 2'b00, 0, 0, 30'h0, 32'h0, 4'h0, 2'b10, 32'h3333_3333);
      vt[9]  = mk(0, 2'b10, 2'b10, 64'h0000_0008_0000_0010, 64'h1234_5678_0000_0000, 8'h30,
                  2'b10, 0, 1, 30'h2, 32'h1234_5678, 4'h3, 2'b00, 32'h0);
      vt[10] = mk(0, 2'b00, 2'b00, AD, 64'h0, 8'h00, 2'b00, 0, 0, 30'h0, 32'h0, 4'h0, 2'b00, 32'h0);
      vt[11] = mk(0, 2'b01, 2'b00, 64'h0000_000C_0000_0008, 64'h0, 8'h00,
                  2'b01, 1, 0, 30'h2, 32'h0, 4'h0, 2'b00, 32'h0);
      vt[12] = mk(0, 2'b00, 2'b00, AD, 64'h0, 8'h00, 2'b00, 0, 0, 30'h0, 32'h0, 4'h0, 2'b01, 32'hAABB_5678);
      vt[13] = mk(0, 2'b11, 2'b00, AD, 64'h0, 8'h00, 2'b10, 1, 0, 30'h3, 32'h0, 4'h0, 2'b00, 32'h0);
      vt[14] = mk(0, 2'b01, 2'b00, AD, 64'h0, 8'h00, 2'b01, 1, 0, 30'h4, 32'h0, 4'h0, 2'b10, 32'h3333_3333);
      vt[15] = mk(0, 2'b01, 2'b00, AD, 64'h0, 8'h00, 2'b01, 1, 0, 30'h4, 32'h0, 4'h0, 2'b01, 32'hDEAD_BEEF);
      vt[16] = mk(0, 2'b00, 2'b00, AD, 64'h0, 8'h00, 2'b00, 0, 0, 30'h0, 32'h0, 4'h0, 2'b01, 32'hDEAD_BEEF);
      vt[17] = mk(0, 2'b00, 2'b00, AD, 64'h0, 8'h00, 2'b00, 0, 0, 30'h0, 32'h0, 4'h0, 2'b00, 32'h0);

      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         a_rst = vt[i].rst; a_req = vt[i].req; a_we = vt[i].we;
         a_addr = vt[i].addr; a_wdata = vt[i].wdata; a_be = vt[i].be;
         @(negedge clk);
         chk($sformatf("A%0d gnt", i),       64'(a_gnt),    64'(vt[i].e_gnt));
         chk($sformatf("A%0d mem_re", i),    64'(a_mre),    64'(vt[i].e_re));
         chk($sformatf("A%0d mem_we", i),    64'(a_mwe),    64'(vt[i].e_we));
         chk($sformatf("A%0d mem_addr", i),  64'(a_maddr),  64'(vt[i].e_addr));
         chk($sformatf("A%0d mem_wdata", i), 64'(a_mwdata), 64'(vt[i].e_wdata));
         chk($sformatf("A%0d mem_be", i),    64'(a_mbe),    64'(vt[i].e_be));
         chk($sformatf("A%0d rvalid", i),    64'(a_rvalid), 64'(vt[i].e_rvalid));
         if (vt[i].e_rvalid != 2'b00)
            chk($sformatf("A%0d rdata", i),  64'(a_rdata),  64'(vt[i].e_rdata));
      end

      // Latency 3: M0, M1, M0 reads in consecutive cycles, responses 3 cycles later.
      cyc_b(1, 2'b00, AD, 2'b00, 30'h0, 2'b00, 32'h0, 0);
      cyc_b(0, 2'b01, AD, 2'b01, 30'h4, 2'b00, 32'h0, 1);
      cyc_b(0, 2'b10, AD, 2'b10, 30'h3, 2'b00, 32'h0, 2);
      cyc_b(0, 2'b01, 64'h0000_000C_0000_0014, 2'b01, 30'h5, 2'b00, 32'h0, 3);
      cyc_b(0, 2'b00, AD, 2'b00, 30'h0, 2'b01, 32'hDEAD_BEEF, 4);
      cyc_b(0, 2'b00, AD, 2'b00, 30'h0, 2'b10, 32'h3333_3333, 5);
      cyc_b(0, 2'b00, AD, 2'b00, 30'h0, 2'b01, 32'h5555_5555, 6);
      cyc_b(0, 2'b00, AD, 2'b00, 30'h0, 2'b00, 32'h0, 7);

      // 4 masters, latency 2: reset drops an in-flight read and restarts at master 0,
      // then 1010 alternates and adding master 0 after a grant to 3 wins next.
      cyc_c(1, 4'b0011, 4'b0000, 0, 4'b0000, 32'h0, 0);
      cyc_c(0, 4'b0001, 4'b0001, 1, 4'b0000, 32'h0, 1);
      cyc_c(1, 4'b0011, 4'b0000, 0, 4'b0000, 32'h0, 2);
      cyc_c(0, 4'b0000, 4'b0000, 0, 4'b0000, 32'h0, 3);
      cyc_c(0, 4'b0011, 4'b0001, 1, 4'b0000, 32'h0, 4);
      cyc_c(0, 4'b1010, 4'b0010, 1, 4'b0000, 32'h0, 5);
      cyc_c(0, 4'b1010, 4'b1000, 1, 4'b0001, 32'hDEAD_BEEF, 6);
      cyc_c(0, 4'b1010, 4'b0010, 1, 4'b0010, 32'h3333_3333, 7);
      cyc_c(0, 4'b1010, 4'b1000, 1, 4'b1000, 32'h5555_5555, 8);
      cyc_c(0, 4'b1011, 4'b0001, 1, 4'b0010, 32'h3333_3333, 9);
      cyc_c(0, 4'b0000, 4'b0000, 0, 4'b1000, 32'h5555_5555, 10);
      cyc_c(0, 4'b0000, 4'b0000, 0, 4'b0001, 32'hDEAD_BEEF, 11);
      cyc_c(0, 4'b0000, 4'b0000, 0, 4'b0000, 32'h0, 12);

      // Single master: grant follows the request, reads answered, writes not.
      cyc_d(1, 1, 0, 0, 0, 0, 0);
      cyc_d(0, 1, 0, 1, 0, 0, 1);
      cyc_d(0, 1, 1, 1, 1, 1, 2);
      cyc_d(0, 0, 0, 0, 0, 0, 3);
      cyc_d(0, 1, 0, 1, 0, 0, 4);
      cyc_d(0, 0, 0, 0, 0, 1, 5);
      chk("D mem_addr idle", 64'(d_maddr), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Parametrised N-master, round-robin arbiter in front of one native-interface memory port. Lets the core's instruction fetch, data port and future masters (DMA, debug) share a single memory port.
- Sits between master-side native memory requests and one port of the on-chip memory in soc_top.
- Performs byte-to-word address conversion.
- Tracks outstanding reads through a fixed-latency pipeline so each master gets back only its own read data.

Parameters:
NUM_MASTERS, 2, number of requesting channels (1..8)
ADDR_W, 32, master byte-address width
DATA_W, 32, data width; multiple of 8
MEM_ADDR_W, 30, memory word-address width
MEM_LATENCY, 1, cycles from mem_re to valid mem_rdata (1..4)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  synchronous, active-high reset
m_req  in  NUM_MASTERS  per-master request valid
m_we  in  NUM_MASTERS  per-master write (1) / read (0)
m_addr  in  NUM_MASTERS*ADDR_W  packed byte addresses, master i at [i*ADDR_W +: ADDR_W]
m_wdata  in  NUM_MASTERS*DATA_W  packed write data
m_be  in  NUM_MASTERS*DATA_W/8  packed byte enables
m_gnt  out  NUM_MASTERS  one-hot grant, request accepted this cycle
m_rvalid  out  NUM_MASTERS  one-hot read-data-valid
m_rdata  out  DATA_W  broadcast read data, qualified by m_rvalid
mem_re  out  1  memory read enable
mem_we  out  1  memory write enable
mem_addr  out  MEM_ADDR_W  word address = granted m_addr >> $clog2(DATA_W/8), truncated
mem_wdata  out  DATA_W  granted write data
mem_be  out  DATA_W/8  granted byte enables
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (rst=1 at clk edge):
  - rr_ptr <= 0.
  - Read-tracking pipeline (MEM_LATENCY entries of {valid, id}) cleared.
- Outputs while rst=1: m_gnt=0, m_rvalid=0, mem_re=0, mem_we=0. mem_addr, mem_wdata and mem_be are 0.
- Arbitration is combinational within the cycle, with at most one grant per cycle:
  - Search m_req starting at index rr_ptr, ascending, wrapping modulo NUM_MASTERS.
  - The first set bit i wins: m_gnt[i]=1.
  - Memory outputs are driven from master i: mem_re = ~m_we[i], mem_we = m_we[i].
- No request: m_gnt=0, mem_re=mem_we=0, rr_ptr unchanged, memory data/address outputs 0.
- Pointer update: on any grant to i, rr_ptr <= (i+1) mod NUM_MASTERS. A master just served has lowest priority next cycle.
- Handshake:
  - A master holds m_req, m_we, m_addr, m_wdata and m_be stable until it sees m_gnt.
  - Dropping m_req before grant is allowed and generates no memory access.
- Writes complete at grant; no response is returned.
- Reads:
  - Stage 0 of the pipeline captures {1, i} on a granted read; otherwise it captures {0, x}.
  - The pipeline shifts every cycle.
  - When the last stage is valid (MEM_LATENCY cycles after the grant), m_rvalid[id]=1 and m_rdata=mem_rdata in that cycle.
  - m_rdata always equals mem_rdata; m_rvalid qualifies it.
- Back-to-back reads, from the same or different masters, sustain one per cycle. Responses return in grant order, one per cycle.
- Single requester: may be granted every cycle with no bubble.
- NUM_MASTERS=1: grant = m_req[0]; rr_ptr is a constant 0.
- Reset mid-operation: in-flight reads are dropped, no m_rvalid follows, and arbitration restarts at master 0.
- No combinational path from mem_rdata to m_gnt.

Test Plan:
- Read, master 0 only, MEM_LATENCY=1: m_req=01, m_we=0, m_addr[0]=0x0000_0010 -> same cycle m_gnt=01, mem_re=1, mem_addr=0x4. Next cycle m_rvalid=01 and m_rdata=mem_rdata (preload 0xDEADBEEF).
- Contention, both masters requesting continuously, reads, from reset -> grants 01,10,01,10 in successive cycles. Responses m_rvalid 01,10,01,10 each delayed MEM_LATENCY.
- Write from master 1: m_addr=0x0000_0008, m_wdata=0x1234_5678, m_be=4'b0011 -> mem_we=1, mem_addr=0x2, mem_be=0011. No m_rvalid follows. Readback returns 0x????5678 with the preload's upper bytes.
- MEM_LATENCY=3, reads to M0 then M1 then M0 in consecutive cycles -> m_rvalid 01,10,01 on cycles 3,4,5 after the first grant, each with the matching data.
- Reset pulse one cycle after a granted read with MEM_LATENCY=2 -> m_rvalid stays 0. The next request with m_req=11 grants master 0.
- NUM_MASTERS=4, m_req=1010 held -> grants alternate 0010,1000. Adding m_req[0] after a grant to master 3 -> next grant 0001.
